mux_scan: RTL and testbench

MUX_SCAN -- requirements
Module: mux_scan

---
 rtl/mux_scan.sv | 165 ++++++++++++++++
 tb/tb_mux_scan.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan.sv
// Registered N-way channel multiplexer with direct selection and optional
// round-robin auto-scan (compiled in by defining MUX_SCAN_AUTOSCAN_EN).
module mux_scan #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 16,
  parameter int DWELL    = 1,
  localparam int SEL_W   = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      sel_valid,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  output logic                      sel_err
);

  localparam int             NSLOT      = 1 << SEL_W;
  localparam logic [SEL_W:0] CH_LIM     = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);
  localparam logic [15:0]    DWELL_LAST = 16'(DWELL - 1);

  logic [WIDTH-1:0] ch_s [NSLOT];
  logic [SEL_W-1:0] cur_ch_r;
  logic [SEL_W-1:0] nxt_ch_s;
  logic [WIDTH-1:0] out_r;
  logic             valid_r;
  logic             err_r;
  logic             scan_s;
  logic             dwell_last_s;
  logic             accept_s;
  logic             bad_req_s;
  logic             advance_s;

  // Scan order wraps from the last real channel to 0, also for non-power-of-two counts.
  function automatic logic [SEL_W-1:0] next_scan(input logic [SEL_W-1:0] c);
    if (c == LAST_CH) begin
      return '0;
    end else begin
      return c + {{(SEL_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Unused index slots read as zero so the select index never leaves the array.
  for (genvar k = 0; k < NSLOT; k++) begin : g_slot
    if (k < CHANNELS) begin : g_used
      assign ch_s[k] = in[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign ch_s[k] = '0;
    end
  end

`ifdef MUX_SCAN_AUTOSCAN_EN
  logic [15:0] dwell_r;

  assign scan_s       = mode;
  assign dwell_last_s = (dwell_r == DWELL_LAST);

  // Dwell counter: held at zero in direct mode, so entering scan always starts a full dwell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_r <= 16'd0;
    end else if (!scan_s || dwell_last_s) begin
      dwell_r <= 16'd0;
    end else begin
      dwell_r <= dwell_r + 16'd1;
    end
  end
`else
  logic unused_cfg_s;

  assign scan_s       = 1'b0;
  assign dwell_last_s = 1'b0;
  assign unused_cfg_s = mode | (|DWELL_LAST);
`endif

  // Next-channel decision; the mode sampled this cycle governs any coincident request.
  always_comb begin
    nxt_ch_s  = cur_ch_r;
    accept_s  = 1'b0;
    bad_req_s = 1'b0;
    advance_s = 1'b0;
    if (scan_s) begin
      advance_s = dwell_last_s;
      if (dwell_last_s) begin
        nxt_ch_s = next_scan(cur_ch_r);
      end else begin
        nxt_ch_s = cur_ch_r;
      end
    end else if (sel_valid) begin
      if ({1'b0, sel} < CH_LIM) begin
        accept_s = 1'b1;
        nxt_ch_s = sel;
      end else begin
        bad_req_s = 1'b1;
      end
    end else begin
      nxt_ch_s = cur_ch_r;
    end
  end

  // Output register: data follows the channel being taken at this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_ch_r <= '0;
      out_r    <= '0;
      valid_r  <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      cur_ch_r <= nxt_ch_s;
      out_r    <= ch_s[nxt_ch_s];
      valid_r  <= valid_r | accept_s | advance_s;
      err_r    <= bad_req_s;
    end
  end

  assign out       = out_r;
  assign out_ch    = cur_ch_r;
  assign out_valid = valid_r;
  assign sel_err   = err_r;

  mux_scan_chk #(
    .SEL_W    (SEL_W),
    .CHANNELS (CHANNELS)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .sel_err   (sel_err)
  );

endmodule

// Runtime invariants of mux_scan outputs.
module mux_scan_chk #(
  parameter int SEL_W    = 4,
  parameter int CHANNELS = 16
) (
  input logic             clk,
  input logic             rst_n,
  input logic             mode,
  input logic [SEL_W-1:0] out_ch,
  input logic             out_valid,
  input logic             sel_err
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  a_ch_range: assert property (@(posedge clk) disable iff (!rst_n) out_ch <= LAST_CH);

  a_valid_sticky: assert property (@(posedge clk) disable iff (!rst_n) out_valid |=> out_valid);

`ifdef MUX_SCAN_AUTOSCAN_EN
  a_no_err_in_scan: assert property (@(posedge clk) disable iff (!rst_n) mode |=> !sel_err);
`else
  logic unused_chk_s;
  assign unused_chk_s = mode | sel_err;
`endif

endmodule

// File: tb/tb_mux_scan.sv
// Scoreboard bench for mux_scan: WIDTH=8, CHANNELS=12, DWELL=3.
module tb_mux_scan;

  localparam int W  = 8;
  localparam int CH = 12;
  localparam int DW = 3;
  localparam int SW = 4;
`ifdef MUX_SCAN_AUTOSCAN_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] ch;
    logic       v;
    logic       e;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CH*W-1:0] in_bus;
  logic [SW-1:0]   sel;
  logic            sel_valid;
  logic            mode;
  logic [W-1:0]    out;
  logic [SW-1:0]   out_ch;
  logic            out_valid;
  logic            sel_err;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic [7:0] ch_val [CH];
  int   m_cur;
  int   m_cnt;
  bit   m_valid;

  always #5 clk = ~clk;

  mux_scan #(.WIDTH(W), .CHANNELS(CH), .DWELL(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in_bus),
    .sel       (sel),
    .sel_valid (sel_valid),
    .mode      (mode),
    .out       (out),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .sel_err   (sel_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: channel pointer, dwell count and sticky valid, stepped once per clock.
  task automatic model_step(input bit v, input int s, input bit m);
    bit e = 1'b0;
    if (AUTO && m) begin
      if (m_cnt == DW - 1) begin
        m_cnt   = 0;
        m_cur   = (m_cur + 1) % CH;
        m_valid = 1'b1;
      end else begin
        m_cnt++;
      end
    end else begin
      m_cnt = 0;
      if (v) begin
        if (s < CH) begin
          m_cur   = s;
          m_valid = 1'b1;
        end else begin
          e = 1'b1;
        end
      end
    end
    exp_q.push_back('{d: ch_val[m_cur], ch: 4'(m_cur), v: m_valid, e: e});
  endtask

  task automatic drive_cycle(input bit v, input int s, input bit m);
    @(negedge clk);
    for (int k = 0; k < CH; k++) in_bus[k*W +: W] = ch_val[k];
    sel       = 4'(s);
    sel_valid = v;
    mode      = m;
    model_step(v, s, m);
  endtask

  task automatic do_reset(input bit with_req);
    @(negedge clk);
    #2;
    rst_n     = 1'b0;
    sel_valid = with_req;
    sel       = 4'd3;
    #1;
    check("rst_out", 32'(out), 32'd0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sel_err", 32'(sel_err), 32'd0);
    exp_q.delete();
    m_cur   = 0;
    m_cnt   = 0;
    m_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_hold_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #2;
    rst_n     = 1'b1;
    sel_valid = 1'b0;
  endtask

  // Monitor: one expected response per clock while out of reset.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b1 && exp_q.size() > 0) begin : pop_blk
        exp_t e;
        e = exp_q.pop_front();
        check("out", 32'(out), 32'(e.d));
        check("out_ch", 32'(out_ch), 32'(e.ch));
        check("out_valid", 32'(out_valid), 32'(e.v));
        check("sel_err", 32'(sel_err), 32'(e.e));
      end
    end
  end

  initial begin
    bit m;
    m         = 1'b0;
    rst_n     = 1'b0;
    sel       = '0;
    sel_valid = 1'b0;
    mode      = 1'b0;
    in_bus    = '0;
    m_cur     = 0;
    m_cnt     = 0;
    m_valid   = 1'b0;
    for (int k = 0; k < CH; k++) ch_val[k] = 8'd0;
    #1;
    check("por_out", 32'(out), 32'd0);
    check("por_out_ch", 32'(out_ch), 32'd0);
    check("por_out_valid", 32'(out_valid), 32'd0);
    check("por_sel_err", 32'(sel_err), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    repeat (6) drive_cycle(1'b0, 0, 1'b0);

    for (int k = 0; k < CH; k++) ch_val[k] = 8'($urandom);
    ch_val[5] = 8'hA5;
    drive_cycle(1'b1, 5, 1'b0);
    ch_val[5] = 8'h3C;
    drive_cycle(1'b0, 0, 1'b0);
    drive_cycle(1'b0, 0, 1'b0);

    drive_cycle(1'b1, 2, 1'b0);
    drive_cycle(1'b1, 13, 1'b0);
    drive_cycle(1'b0, 0, 1'b0);
    drive_cycle(1'b1, 15, 1'b0);
    drive_cycle(1'b1, 12, 1'b0);
    drive_cycle(1'b0, 0, 1'b0);

    drive_cycle(1'b1, 10, 1'b0);
    for (int i = 0; i < 8; i++) drive_cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 1'b1);
    drive_cycle(1'b1, 4, 1'b0);
    drive_cycle(1'b1, 6, 1'b1);
    drive_cycle(1'b1, 14, 1'b1);

    repeat (4) drive_cycle(1'b0, 0, 1'b1);
    do_reset(1'b1);
    repeat (3) drive_cycle(1'b0, 0, 1'b0);
    repeat (5) drive_cycle(1'b0, 0, 1'b1);

    drive_cycle(1'b1, 7, 1'b1);
    repeat (3) drive_cycle(1'b0, 0, 1'b1);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) m = ~m;
      for (int k = 0; k < CH; k++) ch_val[k] = 8'($urandom);
      if ($urandom_range(0, 79) == 0) do_reset(1'($urandom_range(0, 1)));
      drive_cycle(1'($urandom_range(0, 2) == 0), int'($urandom_range(0, 15)), m);
    end

    @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
